// File: rtl/txn_stream_arbiter.sv
// txn_stream_arbiter: packet-locked round-robin arbiter sharing one valid/ready
// channel among NUM_REQ sources, with a forced release after MAX_BURST beats.
module txn_stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [$clog2(NUM_REQ)-1:0]    m_id,
    input  logic                          m_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          burst_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, cand;
    logic [IW-1:0]      ptr_q, ptr_d, gidx, win, j;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               burst_err_q, burst_err_d;
    logic               accept, forced, rel, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant_q[i]) gidx = IW'(i);
    end

    always_comb begin
        grant     = grant_q;
        burst_err = burst_err_q;
        s_ready   = grant_q & {NUM_REQ{m_ready}};
        m_valid   = |(grant_q & s_valid);
        m_id      = gidx;
        m_data    = (|grant_q) ? s_data[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
        accept    = m_valid & m_ready;
        forced    = accept && (cnt_q == CW'(MAX_BURST - 1));
        m_last    = (|grant_q) & (s_last[gidx] | forced);
        rel       = accept & (s_last[gidx] | forced);
    end

    // The releasing source sits out the same-cycle re-arbitration; its valid belongs to the closing beat.
    always_comb begin
        cand = s_valid & ~(rel ? grant_q : '0);
        win  = '0;
        j    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (cand[j]) win = j;
        end
    end

    always_comb begin
        load        = ((state_q == IDLE) || rel) && (|cand);
        state_d     = (state_q == IDLE) ? ((|cand) ? LOCKED : IDLE)
                                        : ((rel && !(|cand)) ? IDLE : LOCKED);
        grant_d     = load ? (NUM_REQ'(1) << win) : (rel ? '0 : grant_q);
        ptr_d       = load ? ((win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
        cnt_d       = rel ? '0 : (accept ? cnt_q + 1'b1 : cnt_q);
        burst_err_d = burst_err_q | (rel & ~s_last[gidx]);
    end
endmodule

// File: tb/tb_txn_stream_arbiter.sv
// tb_txn_stream_arbiter: directed vector tables for the corner cases, then random
// traffic against a transaction-level reference model.
module tb_txn_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    typedef struct {
        logic [3:0] sv, sl;
        logic       rdy;
        logic [3:0] g;
        logic       mv, ml;
        logic [1:0] id;
        logic       err;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_valid = '0, s_last = '0, s_ready, grant;
    logic [N-1:0][DW-1:0] sd = '0;
    logic              m_valid, m_last, m_ready = 1'b0, burst_err;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_id;

    int   checks = 0, errors = 0, step = 0;
    vec_t tbl[$];

    int mg, mptr, mcnt;
    bit merr;

    txn_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(sd), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_id(m_id), .m_ready(m_ready), .grant(grant), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(logic [3:0] sv, logic [3:0] sl, logic rdy, logic [3:0] g,
                       logic mv, logic ml, logic [1:0] id, logic err);
        vec_t v;
        v.sv = sv; v.sl = sl; v.rdy = rdy; v.g = g; v.mv = mv; v.ml = ml; v.id = id; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s_valid = '0; s_last = '0; m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(string name);
        logic [31:0] ed;
        for (int r = 0; r < tbl.size(); r++) begin
            step++;
            s_valid = tbl[r].sv; s_last = tbl[r].sl; m_ready = tbl[r].rdy;
            for (int i = 0; i < N; i++) sd[i] = {8'(i), 8'h5A, step[15:0]};
            #1;
            ed = (tbl[r].g != 0) ? {6'd0, tbl[r].id, 8'h5A, step[15:0]} : 32'd0;
            chk($sformatf("%s[%0d] grant", name, r), 32'(grant), 32'(tbl[r].g));
            chk($sformatf("%s[%0d] m_valid", name, r), 32'(m_valid), 32'(tbl[r].mv));
            chk($sformatf("%s[%0d] m_last", name, r), 32'(m_last), 32'(tbl[r].ml));
            chk($sformatf("%s[%0d] m_id", name, r), 32'(m_id), 32'(tbl[r].id));
            chk($sformatf("%s[%0d] burst_err", name, r), 32'(burst_err), 32'(tbl[r].err));
            chk($sformatf("%s[%0d] s_ready", name, r), 32'(s_ready), 32'(tbl[r].g & {4{tbl[r].rdy}}));
            chk($sformatf("%s[%0d] m_data", name, r), m_data, ed);
            @(negedge clk);
        end
        tbl.delete();
    endtask

    function automatic int pick(logic [3:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    task automatic model_grant(int w);
        mg   = w;
        mptr = (w + 1) % N;
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset grant", 32'(grant), 0);
        chk("reset m_valid", 32'(m_valid), 0);
        chk("reset s_ready", 32'(s_ready), 0);
        chk("reset burst_err", 32'(burst_err), 0);
        chk("reset m_data", m_data, 0);
        @(negedge clk);

        add(4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 1, 0);
        add(4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 1, 0);
        add(4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        run("single");

        do_reset();
        add(4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        for (int q = 0; q < 5; q++) begin
            add(4'b1111, 4'b0000, 1, 4'(1 << (q % 4)), 1, 0, 2'(q % 4), 0);
            add(4'b1111, 4'(1 << (q % 4)), 1, 4'(1 << (q % 4)), 1, 1, 2'(q % 4), 0);
        end
        run("rr_all");

        do_reset();
        add(4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 2, 0);
        add(4'b1101, 4'b0000, 1, 4'b0100, 1, 0, 2, 0);
        add(4'b1101, 4'b0100, 1, 4'b0100, 1, 1, 2, 0);
        add(4'b1001, 4'b1000, 1, 4'b1000, 1, 1, 3, 0);
        add(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 0, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        run("lock");

        do_reset();
        add(4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0011, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0011, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0011, 4'b0000, 1, 4'b0001, 1, 1, 0, 0);
        add(4'b0011, 4'b0000, 1, 4'b0010, 1, 0, 1, 1);
        add(4'b0011, 4'b0010, 1, 4'b0010, 1, 1, 1, 1);
        add(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 1);
        add(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 0, 1);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 1);
        run("forced");

        do_reset();
        add(4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        add(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 0, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        run("coincide");

        do_reset();
        add(4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 3, 0);
        add(4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 3, 0);
        add(4'b1000, 4'b0000, 0, 4'b1000, 1, 0, 3, 0);
        add(4'b1000, 4'b0000, 0, 4'b1000, 1, 0, 3, 0);
        add(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 3, 0);
        add(4'b1000, 4'b1000, 0, 4'b1000, 1, 1, 3, 0);
        add(4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 3, 0);
        add(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        run("stall");

        do_reset();
        add(4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0010, 4'b0000, 1, 4'b0010, 1, 0, 1, 0);
        run("pre_rst");
        s_valid = 4'b0010; m_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst grant", 32'(grant), 0);
        chk("async_rst m_valid", 32'(m_valid), 0);
        chk("async_rst s_ready", 32'(s_ready), 0);
        chk("async_rst m_last", 32'(m_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        add(4'b0101, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        add(4'b0101, 4'b0000, 1, 4'b0001, 1, 0, 0, 0);
        run("post_rst");

        do_reset();
        mg = -1; mptr = 0; mcnt = 0; merr = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  eg, oth, er;
            logic [31:0] ed;
            bit gv, emv, eacc, eml;
            s_valid = 4'($urandom) | 4'($urandom);
            s_last  = 4'($urandom) & 4'($urandom);
            m_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) sd[i] = $urandom;
            #1;
            gv   = (mg >= 0);
            eg   = gv ? 4'(1 << mg) : 4'd0;
            emv  = gv ? s_valid[mg] : 1'b0;
            eacc = emv && m_ready;
            eml  = gv ? (s_last[mg] || (eacc && (mcnt + 1 == MB))) : 1'b0;
            ed   = gv ? sd[mg] : 32'd0;
            er   = m_ready ? eg : 4'd0;
            chk($sformatf("rnd[%0d] grant", c), 32'(grant), 32'(eg));
            chk($sformatf("rnd[%0d] m_valid", c), 32'(m_valid), 32'(emv));
            chk($sformatf("rnd[%0d] m_last", c), 32'(m_last), 32'(eml));
            chk($sformatf("rnd[%0d] m_id", c), 32'(m_id), gv ? 32'(mg) : 32'd0);
            chk($sformatf("rnd[%0d] m_data", c), m_data, ed);
            chk($sformatf("rnd[%0d] s_ready", c), 32'(s_ready), 32'(er));
            chk($sformatf("rnd[%0d] burst_err", c), 32'(burst_err), 32'(merr));
            if (!gv) begin
                if (s_valid != 0) model_grant(pick(s_valid));
            end else if (eacc) begin
                mcnt++;
                if (s_last[mg] || mcnt == MB) begin
                    if (!s_last[mg]) merr = 1;
                    mcnt = 0;
                    oth  = s_valid & ~eg;
                    if (oth != 0) model_grant(pick(oth));
                    else mg = -1;
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
